// File: rtl/uart_pkg.sv
// Shared UART definitions: frame layout, line idle level and the FSM state type
// used by both the transmit serializer and the receiver.
package uart_pkg;

  localparam int PACKET_W   = 11;
  localparam int START_POS  = 0;
  localparam int DATA_LSB   = 1;
  localparam int DATA_MSB   = 8;
  localparam int PARITY_POS = 9;
  localparam int STOP_POS   = 10;
  localparam int IDX_W      = 4;

  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } uart_state_e;

endpackage : uart_pkg

// File: rtl/baud_tick_gen.sv
// Baud-rate divider: counts 0..CLKS_PER_BIT-1 while enabled and pulses tick at
// TICK_AT (terminal count by default; the receiver moves it to mid-bit).
module baud_tick_gen #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned TICK_AT      = CLKS_PER_BIT - 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] TICK = CNT_W'(TICK_AT);

  logic [CNT_W-1:0] cnt_q;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign tick = enable && (cnt_q == TICK);

endmodule : baud_tick_gen

// File: rtl/uart_tx_serializer.sv
// UART transmit serializer: latches an 11-bit frame on start and shifts it out
// LSB-first, one bit per CLKS_PER_BIT clocks, with registered busy/done status.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [PACKET_W-1:0] packet,
  input  logic                tx_start,
  output logic                TxD,
  output logic                tx_busy,
  output logic                tx_done
);

  uart_state_e         state_q, state_d;
  logic [PACKET_W-1:0] shift_q;
  logic [IDX_W-1:0]    idx_q;
  logic                txd_d, busy_d, done_d;
  logic                tick;
  logic                accept;
  logic                last_bit;

  assign accept   = (state_q == IDLE) && tx_start;
  assign last_bit = tick && (idx_q == IDX_W'(STOP_POS));

  baud_tick_gen #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .reset  (reset),
    .clear  (state_q == IDLE),
    .enable (state_q == SHIFT),
    .tick   (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      TxD     <= IDLE_LEVEL;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      state_q <= state_d;
      TxD     <= txd_d;
      tx_busy <= busy_d;
      tx_done <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (tx_start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: every combinational output gets a default first, so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    txd_d  = IDLE_LEVEL;
    busy_d = 1'b0;
    done_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (tx_start) begin
          txd_d  = packet[START_POS];
          busy_d = 1'b1;
        end
      end
      SHIFT: begin
        busy_d = 1'b1;
        txd_d  = tick ? shift_q[1] : shift_q[0];
        if (last_bit) begin
          txd_d  = IDLE_LEVEL;
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Ones shifted in from the top keep the line at idle level past the stop bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shift_q <= {PACKET_W{IDLE_LEVEL}};
      idx_q   <= '0;
    end else if (accept) begin
      shift_q <= packet;
      idx_q   <= '0;
    end else if (state_q == SHIFT && tick) begin
      shift_q <= {IDLE_LEVEL, shift_q[PACKET_W-1:1]};
      idx_q   <= last_bit ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule : uart_tx_serializer

// File: tb/tb_uart_tx_serializer.sv
// Self-checking bench for uart_tx_serializer: three instances (N=2,4,16) checked
// every cycle against a frame-timing model, plus table vectors and corner cases.
module tb_uart_tx_serializer;

  localparam int NS [3] = '{2, 4, 16};

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] packet;
  logic [2:0]  tx_start;
  logic [2:0]  txd, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    uart_tx_serializer #(.CLKS_PER_BIT(NS[g])) u_dut (
      .clk      (clk),
      .reset    (reset),
      .packet   (packet),
      .tx_start (tx_start[g]),
      .TxD      (txd[g]),
      .tx_busy  (busy[g]),
      .tx_done  (done[g])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: a frame accepted at an edge occupies exactly 11*N edges;
  // the line carries frame[elapsed/N]; the edge after the last one reports done.
  int          elapsed [3];
  bit          active  [3];
  logic [10:0] frame   [3];
  logic [2:0]  exp_txd, exp_busy, exp_done;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        active[i]  = 1'b0;
        elapsed[i] = 0;
      end
      exp_txd  = 3'b111;
      exp_busy = 3'b000;
      exp_done = 3'b000;
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_done[i] = 1'b0;
        if (active[i]) begin
          elapsed[i]++;
          if (elapsed[i] == 11 * NS[i]) begin
            active[i]   = 1'b0;
            exp_txd[i]  = 1'b1;
            exp_busy[i] = 1'b0;
            exp_done[i] = 1'b1;
          end else begin
            exp_txd[i] = frame[i][elapsed[i] / NS[i]];
          end
        end else if (tx_start[i]) begin
          active[i]   = 1'b1;
          elapsed[i]  = 0;
          frame[i]    = packet;
          exp_txd[i]  = packet[0];
          exp_busy[i] = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      check($sformatf("model_txd%0d", i),  txd[i],  exp_txd[i]);
      check($sformatf("model_busy%0d", i), busy[i], exp_busy[i]);
      check($sformatf("model_done%0d", i), done[i], exp_done[i]);
    end
  end

  // Sends one frame, sampling the line mid-bit; optionally scrambles packet
  // mid-frame and re-requests a 7FE frame at sample poke_at.
  task automatic send_frame(input int inst, input logic [10:0] pkt, input bit scramble,
                            input int poke_at, output logic [10:0] got, output int len,
                            output int dones);
    logic q[$];
    int   n;
    n     = NS[inst];
    dones = 0;
    @(negedge clk);
    packet         = pkt;
    tx_start[inst] = 1'b1;
    @(negedge clk);
    tx_start[inst] = 1'b0;
    len = 0;
    while (busy[inst] && len < 400) begin
      q.push_back(txd[inst]);
      if (done[inst]) dones++;
      len++;
      if (scramble) packet = 11'($urandom);
      tx_start[inst] = (len == poke_at);
      if (len == poke_at) packet = 11'h7FE;
      @(negedge clk);
    end
    tx_start[inst] = 1'b0;
    if (done[inst]) dones++;
    got = '0;
    for (int k = 0; k < 11; k++)
      if (k * n + n / 2 < q.size()) got[k] = q[k * n + n / 2];
  endtask

  task automatic wait_done(input int inst, output bit ok);
    int k = 0;
    while (!done[inst] && k < 500) begin
      @(negedge clk);
      k++;
    end
    ok = done[inst];
  endtask

  typedef struct {
    logic [10:0] pkt;
    int          inst;
    int          exp_len;
  } vec_t;

  initial begin
    vec_t        vecs [5];
    logic [10:0] got, pkt;
    int          len, dones, inst, t1, t2;
    bit          ok;

    vecs[0] = '{11'h54A, 1, 44};
    vecs[1] = '{11'h6B2, 0, 22};
    vecs[2] = '{11'h6B2, 2, 176};
    vecs[3] = '{11'h000, 1, 44};
    vecs[4] = '{11'h7FF, 0, 22};

    reset = 1'b1; tx_start = '0; packet = '0;
    #1;
    check("rst_txd",  32'(txd),  32'h7);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check("idle_line", {29'd0, txd}, 32'h7);
      check("idle_stat", {26'd0, busy, done}, 32'h0);
    end

    foreach (vecs[v]) begin
      send_frame(vecs[v].inst, vecs[v].pkt, 1'b0, -1, got, len, dones);
      check($sformatf("vec%0d_bits", v),  32'(got), 32'(vecs[v].pkt));
      check($sformatf("vec%0d_len", v),   len,      vecs[v].exp_len);
      check($sformatf("vec%0d_dones", v), dones,    1);
      @(negedge clk);
      check($sformatf("vec%0d_after", v), 32'(txd[vecs[v].inst]), 32'h1);
    end

    // Request while busy must be ignored without resampling packet.
    send_frame(1, 11'h54A, 1'b0, 10, got, len, dones);
    check("busy_req_bits",  32'(got), 32'h54A);
    check("busy_req_len",   len,      44);
    check("busy_req_dones", dones,    1);
    dones = 0;
    repeat (50) begin
      @(negedge clk);
      if (done[1] || busy[1]) dones++;
    end
    check("busy_req_quiet", dones, 0);

    // Back-to-back: start held high; second frame latches the new packet.
    @(negedge clk);
    packet = 11'h401; tx_start[1] = 1'b1;
    wait_done(1, ok);
    check("b2b_done1", 32'(ok), 32'h1);
    t1 = cyc; packet = 11'h7FE;
    @(negedge clk);
    check("b2b_start_bit", {30'd0, busy[1], txd[1]}, 32'h2);
    wait_done(1, ok);
    check("b2b_done2", 32'(ok), 32'h1);
    t2 = cyc; tx_start[1] = 1'b0;
    check("b2b_gap", t2 - t1, 11 * NS[1] + 1);
    repeat (3) @(negedge clk);

    // Reset during data bit 4 (frame bit 5) aborts asynchronously.
    @(negedge clk);
    packet = 11'h54A; tx_start[1] = 1'b1;
    @(negedge clk);
    tx_start[1] = 1'b0;
    repeat (21) @(negedge clk);
    check("mid_busy_pre", 32'(busy[1]), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_txd",  32'(txd[1]),  32'h1);
    check("mid_rst_busy", 32'(busy[1]), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    send_frame(1, 11'h54A, 1'b0, -1, got, len, dones);
    check("post_rst_bits", 32'(got), 32'h54A);
    check("post_rst_len",  len,      44);

    // Random frames with mid-frame packet churn.
    for (int r = 0; r < 20; r++) begin
      inst = $urandom_range(0, 2);
      pkt  = 11'($urandom);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      send_frame(inst, pkt, 1'b1, -1, got, len, dones);
      check($sformatf("rnd%0d_bits", r),  32'(got), 32'(pkt));
      check($sformatf("rnd%0d_len", r),   len,      11 * NS[inst]);
      check($sformatf("rnd%0d_dones", r), dones,    1);
    end

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_uart_tx_serializer
